// File: rtl/dcache_pkg.sv
// Shared constants for the data-cache slice: FSM encoding and ALU/opcode values.
// Latency: n/a (constants only).
// Backpressure: n/a.
package dcache_pkg;

  // Cache controller FSM encoding
  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_FILL  = 2'd1;
  localparam logic [STATE_W-1:0] ST_WRITE = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

  // Core ALU / opcode constants shared with the datapath
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped tag/valid/data storage: one combinational read port, one write port.
// Latency: reads are combinational; writes land on the next rising edge.
// Backpressure: none; the write port is accepted every cycle wr_en is high.
module dcache_array #(
  parameter int NBITS  = 8,
  parameter int NLINES = 8,
  localparam int IDXW  = $clog2(NLINES),
  localparam int TAGW  = NBITS - IDXW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDXW-1:0]  rd_idx,
  output logic             rd_vld,
  output logic [TAGW-1:0]  rd_tag,
  output logic [NBITS-1:0] rd_dat,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_idx,
  input  logic [TAGW-1:0]  wr_tag,
  input  logic [NBITS-1:0] wr_dat
);

  logic [NLINES-1:0] valid_q, valid_d;
  logic [TAGW-1:0]   tag_q  [NLINES];
  logic [NBITS-1:0]  data_q [NLINES];

  // Any write to a line makes it valid (fills and write hits alike)
  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_idx] = 1'b1;
  end

  // Valid bits are the only storage that must come out of reset clean
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tag and data arrays carry no reset; valid bits mask stale contents
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_dat;
    end
  end

  // Combinational read port
  always_comb begin
    rd_vld = valid_q[rd_idx];
    rd_tag = tag_q[rd_idx];
    rd_dat = data_q[rd_idx];
  end

endmodule

// File: rtl/dcache.sv
// Write-through, no-write-allocate direct-mapped data cache with a blocking controller FSM.
// Latency: read hit zero wait states; miss/write = request cycle + memory cycles until ack + DONE.
// Backpressure: busy stalls the controller until the backing-memory ack completes the request.
module dcache
  import dcache_pkg::*;
#(
  parameter int NBITS  = 8,
  parameter int NLINES = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [NBITS-1:0] Addr,
  input  logic [NBITS-1:0] WriteData,
  output logic [NBITS-1:0] ReadData,
  output logic             busy,
  output logic             mem_req,
  output logic             mem_we,
  output logic [NBITS-1:0] mem_addr,
  output logic [NBITS-1:0] mem_wdata,
  input  logic [NBITS-1:0] mem_rdata,
  input  logic             mem_ack
);

  localparam int IDXW = $clog2(NLINES);
  localparam int TAGW = NBITS - IDXW;

  logic [STATE_W-1:0] state_q, state_d;
  logic [NBITS-1:0]   addr_q, addr_d;
  logic [NBITS-1:0]   wdata_q, wdata_d;
  logic [NBITS-1:0]   rdata_q, rdata_d;

  logic [NBITS-1:0]   lk_addr;
  logic [IDXW-1:0]    rd_idx;
  logic               rd_vld;
  logic [TAGW-1:0]    rd_tag;
  logic [NBITS-1:0]   rd_dat;
  logic               hit;
  logic               wr_en;
  logic [NBITS-1:0]   wr_dat;

  dcache_array #(
    .NBITS  (NBITS),
    .NLINES (NLINES)
  ) u_array (
    .clock  (clock),
    .reset  (reset),
    .rd_idx (rd_idx),
    .rd_vld (rd_vld),
    .rd_tag (rd_tag),
    .rd_dat (rd_dat),
    .wr_en  (wr_en),
    .wr_idx (addr_q[IDXW-1:0]),
    .wr_tag (addr_q[NBITS-1:IDXW]),
    .wr_dat (wr_dat)
  );

  // Lookup uses the live address in IDLE and the latched one while a write is in flight
  always_comb begin
    lk_addr = (state_q == ST_IDLE) ? Addr : addr_q;
    rd_idx  = lk_addr[IDXW-1:0];
    hit     = rd_vld && (rd_tag == lk_addr[NBITS-1:IDXW]);
  end

  // Controller next-state, outputs and array write control
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    busy     = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    ReadData = '0;
    wr_en    = 1'b0;
    wr_dat   = mem_rdata;

    case (state_q)
      ST_IDLE: begin
        // A simultaneous read and write is serviced as the write alone
        if (MemWrite) begin
          busy    = 1'b1;
          addr_d  = Addr;
          wdata_d = WriteData;
          rdata_d = '0;
          state_d = ST_WRITE;
        end else if (MemRead) begin
          if (hit) begin
            ReadData = rd_dat;
          end else begin
            busy    = 1'b1;
            addr_d  = Addr;
            rdata_d = '0;
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          wr_en   = 1'b1;
          wr_dat  = mem_rdata;
          rdata_d = mem_rdata;
          state_d = ST_DONE;
        end
      end
      ST_WRITE: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          // Write-through: refresh the line only if it already holds this address
          wr_en   = hit;
          wr_dat  = wdata_q;
          state_d = ST_DONE;
        end
      end
      default: begin
        ReadData = rdata_q;
        state_d  = ST_IDLE;
      end
    endcase

    // Asynchronous reset forces the controller-facing outputs quiet at once
    if (!reset) begin
      busy     = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      ReadData = '0;
    end
  end

  // Backing-memory address/data always reflect the latched request
  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
  end

  // Controller state and request latches
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Directed self-checking bench for dcache (NBITS=8, NLINES=8).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
// The bench plays the backing memory, acking after a chosen number of cycles.
module tb_dcache;

  logic       clock;
  logic       reset;
  logic       MemRead;
  logic       MemWrite;
  logic [7:0] Addr;
  logic [7:0] WriteData;
  logic [7:0] ReadData;
  logic       busy;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;

  int n_chk  = 0;
  int n_pass = 0;

  dcache #(.NBITS(8), .NLINES(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Read expected to hit: data appears in the same cycle, no memory traffic
  task automatic read_hit(input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    MemRead = 1'b1; MemWrite = 1'b0; Addr = a;
    #1;
    chk("hit_busy", busy, 0);
    chk("hit_data", ReadData, d);
    chk("hit_req", mem_req, 0);
    @(negedge clock);
    MemRead = 1'b0;
    #1;
    chk("idle_data", ReadData, 0);
  endtask

  // Read expected to miss; memory acks in FILL cycle n with data d
  task automatic read_miss(input logic [7:0] a, input logic [7:0] d, input int n);
    int busy_cnt;
    @(negedge clock);
    MemRead = 1'b1; MemWrite = 1'b0; Addr = a;
    #1;
    chk("miss_busy_req", busy, 1);
    chk("miss_req_cycle_memreq", mem_req, 0);
    busy_cnt = 1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clock);
      MemRead = 1'b0; Addr = 8'hFF;
      mem_ack = (i == n); mem_rdata = (i == n) ? d : 8'hEE;
      #1;
      chk("fill_req", mem_req, 1);
      chk("fill_we", mem_we, 0);
      chk("fill_addr", mem_addr, a);
      if (busy) busy_cnt++;
    end
    @(negedge clock);
    mem_ack = 1'b0;
    #1;
    chk("done_busy", busy, 0);
    chk("done_data", ReadData, d);
    chk("done_req", mem_req, 0);
    chk("busy_cycles", busy_cnt, n + 1);
  endtask

  // Store (optionally with MemRead also raised); memory acks in WRITE cycle n
  task automatic write_op(input logic [7:0] a, input logic [7:0] d, input int n, input logic rd_too);
    @(negedge clock);
    MemWrite = 1'b1; MemRead = rd_too; Addr = a; WriteData = d;
    #1;
    chk("wr_busy_req", busy, 1);
    for (int i = 1; i <= n; i++) begin
      @(negedge clock);
      MemWrite = 1'b0; MemRead = 1'b0; Addr = 8'hFF; WriteData = 8'h00;
      mem_ack = (i == n);
      #1;
      chk("wr_req", mem_req, 1);
      chk("wr_we", mem_we, 1);
      chk("wr_addr", mem_addr, a);
      chk("wr_wdata", mem_wdata, d);
      chk("wr_busy", busy, 1);
    end
    @(negedge clock);
    mem_ack = 1'b0;
    #1;
    chk("wr_done_busy", busy, 0);
    chk("wr_done_data", ReadData, 0);
    chk("wr_done_req", mem_req, 0);
  endtask

  initial begin
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Addr = 8'h00; WriteData = 8'h00; mem_rdata = 8'h00; mem_ack = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_data", ReadData, 0);
    @(negedge clock);
    reset = 1'b1;

    // Cold miss, then hit on the same address
    read_miss(8'h13, 8'hA5, 1);
    read_hit(8'h13, 8'hA5);
    // Same index, different tag: slow memory, line replaced
    read_miss(8'h1B, 8'h3C, 3);
    // Write hit updates the line through to memory
    write_op(8'h1B, 8'h77, 2, 1'b0);
    read_hit(8'h1B, 8'h77);
    // Original tag was evicted
    read_miss(8'h13, 8'hA5, 1);
    // Write miss does not allocate
    write_op(8'h40, 8'h99, 1, 1'b0);
    read_miss(8'h40, 8'h55, 1);
    // Read and write together: write only, no allocation
    write_op(8'h05, 8'h11, 1, 1'b1);
    read_miss(8'h05, 8'h11, 2);

    // Stray ack in IDLE has no effect
    @(negedge clock);
    mem_ack = 1'b1; mem_rdata = 8'h99;
    #1;
    chk("stray_ack_busy", busy, 0);
    chk("stray_ack_req", mem_req, 0);
    @(negedge clock);
    mem_ack = 1'b0;
    read_hit(8'h13, 8'hA5);

    // Reset during FILL before the ack
    @(negedge clock);
    MemRead = 1'b1; Addr = 8'h2A;
    #1;
    chk("rf_busy_req", busy, 1);
    @(negedge clock);
    MemRead = 1'b0;
    #1;
    chk("rf_fill_req", mem_req, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("rf_busy_now", busy, 0);
    chk("rf_req_now", mem_req, 0);
    chk("rf_data_now", ReadData, 0);
    @(negedge clock);
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h66;
    #1;
    chk("rf_late_ack_busy", busy, 0);
    chk("rf_late_ack_req", mem_req, 0);
    @(negedge clock);
    mem_ack = 1'b0;
    read_miss(8'h13, 8'hA5, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 Parameter NBITS, default 8: data and address width.
REQ-002 Parameter NLINES, default 8, power of two: number of direct-mapped lines, one NBITS word per line.
REQ-003 clock  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 MemRead  input  1  read request from controller.
REQ-006 MemWrite  input  1  write request from controller.
REQ-007 Addr  input  NBITS  byte address (ALU result).
REQ-008 WriteData  input  NBITS  store data (RS2 value).
REQ-009 ReadData  output  NBITS  load data to MemtoReg mux.
REQ-010 busy  output  1  stall to controller; high while request not complete.
REQ-011 mem_req  output  1  backing-memory request.
REQ-012 mem_we  output  1  backing-memory write enable, qualifies mem_req.
REQ-013 mem_addr  output  NBITS  backing-memory address.
REQ-014 mem_wdata  output  NBITS  backing-memory write data.
REQ-015 mem_rdata  input  NBITS  backing-memory read data, valid with mem_ack.
REQ-016 mem_ack  input  1  one-cycle completion pulse from backing memory.

Function
REQ-017 Organisation: direct-mapped, index = Addr[log2(NLINES)-1:0], tag = remaining upper Addr bits, one valid bit per line; write-through, no-write-allocate.
REQ-018 FSM states IDLE, FILL, WRITE, DONE; only IDLE samples MemRead/MemWrite/Addr/WriteData.
REQ-019 IDLE, no request: busy=0, mem_req=0, ReadData=0.
REQ-020 IDLE, MemRead read hit: busy=0, ReadData = line data combinationally in same cycle (zero wait states), state stays IDLE.
REQ-021 IDLE, MemRead miss: busy=1 combinationally in same cycle; Addr latched; next state FILL.
REQ-022 IDLE, MemWrite: busy=1 combinationally; Addr and WriteData latched; next state WRITE.
REQ-023 MemRead and MemWrite both high in IDLE: treated as write only.
REQ-024 FILL: mem_req=1, mem_we=0, mem_addr=latched Addr, busy=1, held until mem_ack; on mem_ack write mem_rdata into line, set valid, update tag, capture data, go DONE.
REQ-025 WRITE: mem_req=1, mem_we=1, mem_addr/mem_wdata=latched values, busy=1, held until mem_ack; on mem_ack, if latched address hits, update line data; go DONE.
REQ-026 DONE: busy=0, mem_req=0, ReadData = captured fill data (0 after write); unconditional return to IDLE next cycle; inputs ignored in DONE.
REQ-027 Minimum miss latency: request cycle + FILL cycles until mem_ack + DONE; with mem_ack in first FILL cycle, busy high exactly 2 cycles.
REQ-028 Inputs changing while in FILL/WRITE have no effect; mem_ack outside FILL/WRITE is ignored.
REQ-029 ReadData is 0 in every state/case not listed above.

Reset
REQ-030 reset low, at any time including mid-FILL/WRITE: state=IDLE, all valid bits cleared, latches cleared, mem_req=0, busy=0, ReadData=0 immediately (asynchronous).
REQ-031 Line data and tags need not be reset; valid bits guarantee misses after reset.
REQ-032 First rising edge after reset deasserts behaves as IDLE.

Structure
REQ-033 FSM state enum and state-width constant placed in the shared package with the ALU/opcode constants.
REQ-034 One sub-module natural: dcache_array (tag/valid/data storage, one read port, one write port, async-reset valid bits); FSM stays in dcache.

Verification
REQ-035 Reset then MemRead Addr=0x13: busy=1 same cycle, mem_req=1 mem_we=0 mem_addr=0x13; memory acks with 0xA5 -> DONE cycle busy=0 ReadData=0xA5.
REQ-036 Repeat MemRead 0x13: busy=0, ReadData=0xA5 same cycle, mem_req stays 0.
REQ-037 MemRead 0x1B (same index 3, different tag), ack 0x3C after 3 cycles -> busy high 4 cycles, ReadData=0x3C; then read 0x13 misses again.
REQ-038 MemWrite 0x1B data 0x77 -> mem_req=1 mem_we=1 mem_wdata=0x77 until ack; subsequent MemRead 0x1B hits with 0x77; MemWrite 0x40 (miss) does not allocate, next read 0x40 misses.
REQ-039 MemRead and MemWrite together at 0x05 data 0x11 -> write cycle only (mem_we=1), no fill.
REQ-040 reset asserted during FILL before ack -> busy=0, mem_req=0 immediately; late mem_ack ignored; read of previously hit 0x13 misses.
